// File: rtl/bnn_ctrl_pkg.sv
// Shared types and constants for the BNN inference sequencer.
//   seq_state_t          : sequencer FSM states
//   IMG_BITS / IMG_BYTES : default image bus width and bytes per frame
//   NUM_CLASSES          : valid class codes are 0..NUM_CLASSES-1
//   RESULT_TIMEOUT_CODE  : class code reported when the BNN never answers
package bnn_ctrl_pkg;
    localparam int         IMG_BITS            = 904;
    localparam int         IMG_BYTES           = IMG_BITS / 8;
    localparam int         NUM_CLASSES         = 10;
    localparam logic [3:0] RESULT_TIMEOUT_CODE = 4'hF;

    typedef enum logic [2:0] {COLLECT, START, WAIT, REPORT, CLEAR} seq_state_t;
endpackage

// File: rtl/bnn_img_buffer.sv
// Byte-to-image packer. Each accepted byte shifts in at the LSB end, so the first byte
// of a frame ends up in the top byte of img_out once the frame is complete.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_data     : byte to shift in
//   accept      : shift rx_data in this cycle
//   clear       : zero the byte count (image contents are kept)
//   img_out     : packed image
//   count       : bytes received in the current frame
//   frame_done  : strobe, high in the cycle the last byte of a frame is accepted
module bnn_img_buffer #(
    parameter int IMG_BITS  = 904,
    parameter int IMG_BYTES = IMG_BITS / 8,
    localparam int CNT_W    = $clog2(IMG_BYTES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                accept,
    input  logic                clear,
    output logic [IMG_BITS-1:0] img_out,
    output logic [CNT_W-1:0]    count,
    output logic                frame_done
);
    logic last_byte;

    assign last_byte  = (count == CNT_W'(IMG_BYTES - 1));
    assign frame_done = accept && last_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_out <= '0;
            count   <= '0;
        end else begin
            if (accept)
                img_out <= {img_out[IMG_BITS-9:0], rx_data};
            if (clear)
                count <= '0;
            else if (accept)
                count <= last_byte ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/bnn_sequencer.sv
// Runs one BNN inference per received image: collects IMG_BYTES bytes, enables the
// BNN, waits for its result (or times out), holds the class for the consumer until
// acknowledged, then pulses bnn_clear to re-arm the BNN.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready  : byte stream in, accepted on rx_valid && rx_ready
//   img_out                    : packed image to the BNN
//   img_buffer_full            : frame complete, held until CLEAR exits
//   bnn_enable / bnn_clear     : BNN run / re-arm controls
//   result_ready / result_in   : BNN result handshake
//   res_valid/res_data/res_err : result held for the consumer; res_ack accepts it
//   abort                      : synchronous soft abort from any state
//   busy                       : not idle in COLLECT with an empty frame
module bnn_sequencer #(
    parameter int IMG_BITS       = bnn_ctrl_pkg::IMG_BITS,
    parameter int IMG_BYTES      = IMG_BITS / 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [IMG_BITS-1:0] img_out,
    output logic                img_buffer_full,
    output logic                bnn_enable,
    output logic                bnn_clear,
    input  logic                result_ready,
    input  logic [3:0]          result_in,
    output logic                res_valid,
    output logic [3:0]          res_data,
    output logic                res_err,
    input  logic                res_ack,
    input  logic                abort,
    output logic                busy
);
    import bnn_ctrl_pkg::*;

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t                     state;
    logic [TO_W-1:0]                tcnt;
    logic [$clog2(IMG_BYTES)-1:0]   count;
    logic                           accept;
    logic                           frame_done;

    // rx_ready is only ever high in COLLECT; abort takes priority over a byte.
    assign accept = rx_ready && rx_valid && !abort;
    assign busy   = (state != COLLECT) || (count != '0);

    bnn_img_buffer #(
        .IMG_BITS  (IMG_BITS),
        .IMG_BYTES (IMG_BYTES)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .accept     (accept),
        .clear      (abort),
        .img_out    (img_out),
        .count      (count),
        .frame_done (frame_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= COLLECT;
            tcnt            <= '0;
            rx_ready        <= 1'b1;
            img_buffer_full <= 1'b0;
            bnn_enable      <= 1'b0;
            bnn_clear       <= 1'b0;
            res_valid       <= 1'b0;
            res_data        <= '0;
            res_err         <= 1'b0;
        end else if (abort) begin
            // Any state, including CLEAR, funnels through CLEAR; a pending result is dropped.
            state      <= CLEAR;
            rx_ready   <= 1'b0;
            bnn_enable <= 1'b0;
            bnn_clear  <= 1'b1;
            res_valid  <= 1'b0;
        end else begin
            case (state)
                COLLECT: if (frame_done) begin
                    state           <= START;
                    rx_ready        <= 1'b0;
                    bnn_enable      <= 1'b1;
                    img_buffer_full <= 1'b1;
                end
                START: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    // A result arriving on the final timeout cycle still counts as a result.
                    if (result_ready) begin
                        res_data   <= result_in;
                        res_err    <= (result_in >= 4'(NUM_CLASSES));
                        res_valid  <= 1'b1;
                        bnn_enable <= 1'b0;
                        state      <= REPORT;
                    end else if (tcnt == TO_LAST) begin
                        res_data   <= RESULT_TIMEOUT_CODE;
                        res_err    <= 1'b1;
                        res_valid  <= 1'b1;
                        bnn_enable <= 1'b0;
                        state      <= REPORT;
                    end
                end
                REPORT: if (res_ack) begin
                    res_valid <= 1'b0;
                    bnn_clear <= 1'b1;
                    state     <= CLEAR;
                end
                CLEAR: if (!result_ready) begin
                    // The BNN drops result_ready one cycle after seeing bnn_clear.
                    bnn_clear       <= 1'b0;
                    img_buffer_full <= 1'b0;
                    rx_ready        <= 1'b1;
                    state           <= COLLECT;
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_sequencer.sv
module tb_bnn_sequencer;
    localparam int IB = 904;
    localparam int NB = 113;

    typedef struct {
        logic [3:0] data;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default timeout, driven by a mock BNN
    logic [7:0]    rx_data;
    logic          rx_valid, abort, res_ack, result_ready;
    logic [3:0]    result_in;
    logic          rx_ready, img_buffer_full, bnn_enable, bnn_clear, res_valid, res_err, busy;
    logic [IB-1:0] img_out;
    logic [3:0]    res_data;

    // DUT B: short timeout, BNN never answers
    logic          rx_valid_b, abort_b, res_ack_b, result_ready_b;
    logic [3:0]    result_in_b;
    logic          rx_ready_b, img_buffer_full_b, bnn_enable_b, bnn_clear_b, res_valid_b, res_err_b, busy_b;
    logic [IB-1:0] img_out_b;
    logic [3:0]    res_data_b;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    logic [IB-1:0] exp_img;

    int         en_cnt;
    int         mock_delay = 0;
    logic [3:0] mock_val = 4'd0;

    bnn_sequencer dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .img_out(img_out), .img_buffer_full(img_buffer_full), .bnn_enable(bnn_enable),
        .bnn_clear(bnn_clear), .result_ready(result_ready), .result_in(result_in),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .res_ack(res_ack),
        .abort(abort), .busy(busy)
    );

    bnn_sequencer #(.TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .img_out(img_out_b), .img_buffer_full(img_buffer_full_b), .bnn_enable(bnn_enable_b),
        .bnn_clear(bnn_clear_b), .result_ready(result_ready_b), .result_in(result_in_b),
        .res_valid(res_valid_b), .res_data(res_data_b), .res_err(res_err_b), .res_ack(res_ack_b),
        .abort(abort_b), .busy(busy_b)
    );

    // Mock BNN: raises result_ready on the mock_delay-th enabled cycle after START,
    // holds it until it sees bnn_clear, then drops it on the following edge.
    assign result_in = mock_val;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cnt       <= 0;
            result_ready <= 1'b0;
        end else if (bnn_clear) begin
            en_cnt       <= 0;
            result_ready <= 1'b0;
        end else if (bnn_enable) begin
            en_cnt <= en_cnt + 1;
            if (en_cnt + 1 == mock_delay)
                result_ready <= 1'b1;
        end
    end

    function automatic int first_diff(input logic [IB-1:0] a, input logic [IB-1:0] b);
        for (int j = NB - 1; j >= 0; j--)
            if (a[j*8 +: 8] !== b[j*8 +: 8]) return j;
        return -1;
    endfunction

    // Drives n bytes back to back starting #1 after a posedge; returns #1 after the last accept edge.
    task automatic send_bytes(input bit to_b, input int base, input int step, input int n);
        for (int i = 0; i < n; i++) begin
            rx_data = 8'(base + i * step);
            exp_img = {exp_img[IB-9:0], rx_data};
            if (to_b) rx_valid_b = 1'b1; else rx_valid = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid   = 1'b0;
        rx_valid_b = 1'b0;
    endtask

    task automatic run_until_report(input bit to_b, output int en_cycles, output bit seen);
        en_cycles = 0;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (to_b ? res_valid_b : res_valid) begin
                seen = 1'b1;
                break;
            end
            if (to_b ? bnn_enable_b : bnn_enable) en_cycles++;
        end
    endtask

    // Pulses res_ack from a negedge and counts bnn_clear cycles until rx_ready returns.
    task automatic ack_and_drain(input bit to_b, output int clr_cycles, output bit back);
        clr_cycles = 0;
        back = 1'b0;
        @(negedge clk);
        if (to_b) res_ack_b = 1'b1; else res_ack = 1'b1;
        @(posedge clk); #1;
        res_ack = 1'b0;
        res_ack_b = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (to_b ? rx_ready_b : rx_ready) begin
                back = 1'b1;
                break;
            end
            if (to_b ? bnn_clear_b : bnn_clear) clr_cycles++;
        end
    endtask

    task automatic test_reset;
        #12;
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b want=1", rx_ready); end
        total++; if ({img_buffer_full, bnn_enable, bnn_clear, res_valid, res_err, busy} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000",
                            {img_buffer_full, bnn_enable, bnn_clear, res_valid, res_err, busy});
        end
        total++; if (res_data !== 4'h0) begin bad++; $display("FAIL reset_res_data got=%h want=0", res_data); end
        total++; if (img_out !== '0) begin bad++; $display("FAIL reset_img got_byte=%0d want=all_zero", first_diff(img_out, '0)); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame_result;
        exp_t e;
        int   en_cycles, clr;
        bit   seen, back;
        mock_delay = 20;
        mock_val   = 4'd7;
        exp_q.push_back('{data: 4'd7, err: 1'b0});
        send_bytes(1'b0, 0, 1, NB);
        total++; if ({bnn_enable, img_buffer_full, rx_ready, busy} !== 4'b1101) begin
            bad++; $display("FAIL frame_start got=%b want=1101", {bnn_enable, img_buffer_full, rx_ready, busy});
        end
        total++; if (img_out[903:896] !== 8'h00 || img_out[7:0] !== 8'h70) begin
            bad++; $display("FAIL frame_ends got=%h/%h want=00/70", img_out[903:896], img_out[7:0]);
        end
        total++; if (img_out !== exp_img) begin bad++; $display("FAIL frame_img first_bad_byte=%0d want=-1", first_diff(img_out, exp_img)); end
        run_until_report(1'b0, en_cycles, seen);
        total++; if (!seen || en_cycles != 21) begin
            bad++; $display("FAIL frame_enable_len got=%0d seen=%b want=21 seen=1", en_cycles, seen);
        end
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL frame_scoreboard got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            total++; if (res_data !== e.data || res_err !== e.err || bnn_enable !== 1'b0) begin
                bad++; $display("FAIL frame_result got=%h/%b en=%b want=%h/%b en=0", res_data, res_err, bnn_enable, e.data, e.err);
            end
        end
        ack_and_drain(1'b0, clr, back);
        total++; if (!back || clr != 2) begin bad++; $display("FAIL frame_clear got=%0d back=%b want=2 back=1", clr, back); end
        total++; if (busy !== 1'b0 || img_buffer_full !== 1'b0 || img_out !== exp_img) begin
            bad++; $display("FAIL frame_rearm busy=%b full=%b img_byte=%0d want 0 0 -1", busy, img_buffer_full, first_diff(img_out, exp_img));
        end
    endtask

    task automatic test_bad_class;
        exp_t e;
        int   en_cycles, clr, unstable;
        bit   seen, back;
        mock_delay = 5;
        mock_val   = 4'd12;
        exp_q.push_back('{data: 4'd12, err: 1'b1});
        send_bytes(1'b0, 8'hA0, 1, NB);
        // rx_valid held high outside COLLECT must not shift anything in
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        run_until_report(1'b0, en_cycles, seen);
        total++; if (!seen || en_cycles != 6) begin bad++; $display("FAIL bad_enable_len got=%0d seen=%b want=6 seen=1", en_cycles, seen); end
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL bad_scoreboard got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            total++; if (res_data !== e.data || res_err !== e.err) begin
                bad++; $display("FAIL bad_result got=%h/%b want=%h/%b", res_data, res_err, e.data, e.err);
            end
        end
        unstable = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 4'd12 || res_err !== 1'b1 || rx_ready !== 1'b0) unstable++;
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL bad_hold got=%0d_unstable_cycles want=0", unstable); end
        total++; if (img_out !== exp_img) begin bad++; $display("FAIL bad_img_kept first_bad_byte=%0d want=-1", first_diff(img_out, exp_img)); end
        rx_valid = 1'b0;
        ack_and_drain(1'b0, clr, back);
        total++; if (!back || res_valid !== 1'b0) begin bad++; $display("FAIL bad_rearm back=%b res_valid=%b want=1 0", back, res_valid); end
    endtask

    task automatic test_abort;
        exp_t e;
        int   en_cycles, clr;
        bit   seen, back;
        mock_delay = 8;
        mock_val   = 4'd3;
        send_bytes(1'b0, 8'h10, 1, 40);
        total++; if (busy !== 1'b1 || rx_ready !== 1'b1) begin bad++; $display("FAIL abort_partial busy=%b rdy=%b want=1 1", busy, rx_ready); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if ({bnn_clear, rx_ready, busy} !== 3'b101) begin
            bad++; $display("FAIL abort_clear got=%b want=101", {bnn_clear, rx_ready, busy});
        end
        @(posedge clk); #1;
        total++; if ({bnn_clear, rx_ready, busy} !== 3'b010) begin
            bad++; $display("FAIL abort_exit got=%b want=010", {bnn_clear, rx_ready, busy});
        end
        exp_q.push_back('{data: 4'd3, err: 1'b0});
        send_bytes(1'b0, 8'h03, 3, NB);
        run_until_report(1'b0, en_cycles, seen);
        total++; if (!seen || img_out !== exp_img) begin
            bad++; $display("FAIL abort_new_frame seen=%b first_bad_byte=%0d want=1 -1", seen, first_diff(img_out, exp_img));
        end
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL abort_scoreboard got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            total++; if (res_data !== e.data || res_err !== e.err) begin
                bad++; $display("FAIL abort_result got=%h/%b want=%h/%b", res_data, res_err, e.data, e.err);
            end
        end
        ack_and_drain(1'b0, clr, back);
        total++; if (!back) begin bad++; $display("FAIL abort_rearm got=0 want=1"); end
    endtask

    task automatic test_timeout;
        exp_t e;
        int   en_cycles, clr;
        bit   seen, back;
        exp_q.push_back('{data: 4'hF, err: 1'b1});
        send_bytes(1'b1, 8'h20, 1, NB);
        run_until_report(1'b1, en_cycles, seen);
        total++; if (!seen || en_cycles != 17) begin bad++; $display("FAIL timeout_len got=%0d seen=%b want=17 seen=1", en_cycles, seen); end
        if (exp_q.size() == 0) begin total++; bad++; $display("FAIL timeout_scoreboard got=empty want=entry"); end
        else begin
            e = exp_q.pop_front();
            total++; if (res_data_b !== e.data || res_err_b !== e.err) begin
                bad++; $display("FAIL timeout_result got=%h/%b want=%h/%b", res_data_b, res_err_b, e.data, e.err);
            end
        end
        ack_and_drain(1'b1, clr, back);
        total++; if (!back || clr != 1 || rx_ready_b !== 1'b1 || busy_b !== 1'b0) begin
            bad++; $display("FAIL timeout_rearm clr=%0d back=%b rdy=%b busy=%b want=1 1 1 0", clr, back, rx_ready_b, busy_b);
        end
    endtask

    task automatic test_async_reset;
        int en_seen;
        mock_delay = 20;
        mock_val   = 4'd5;
        send_bytes(1'b0, 8'h40, 1, NB);
        en_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bnn_enable === 1'b1) en_seen++;
        end
        total++; if (en_seen != 5) begin bad++; $display("FAIL areset_pre got=%0d want=5", en_seen); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({bnn_enable, rx_ready, res_valid, img_buffer_full, busy} !== 5'b01000 || img_out !== '0) begin
            bad++; $display("FAIL areset_now got=%b img_zero=%b want=01000 1",
                            {bnn_enable, rx_ready, res_valid, img_buffer_full, busy}, img_out === '0);
        end
        exp_img = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rx_data = 8'h00; rx_valid = 1'b0; abort = 1'b0; res_ack = 1'b0;
        rx_valid_b = 1'b0; abort_b = 1'b0; res_ack_b = 1'b0; result_ready_b = 1'b0; result_in_b = 4'd0;
        exp_img = '0;
        test_reset();
        test_frame_result();
        test_bad_class();
        test_abort();
        test_timeout();
        test_async_reset();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
